// File: rtl/restoring_div16_pkg.sv
// restoring_div16_pkg: package alu_pkg with the divider state type and shared constants
package alu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    localparam int DIV_W = 16;
    localparam int DIV_CNT_W = 4;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = 4'd15;
endpackage

// File: rtl/restoring_div16_if.sv
// restoring_div16_if: ALU-to-divider request/result bundle; signed_op exists only with SIGNED_DIV_EN
interface restoring_div16_if;
    import alu_pkg::*;
    logic             start;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div_by_zero;
    modport master (
`ifdef SIGNED_DIV_EN
        output signed_op,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
`ifdef SIGNED_DIV_EN
        input  signed_op,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/scazfsc.sv
// scazfsc: 16-bit borrow subtractor, {o_bout, o_diff} = i_x - i_y - i_b
module scazfsc
    import alu_pkg::*;
(
    input  logic [DIV_W-1:0] i_x,
    input  logic [DIV_W-1:0] i_y,
    input  logic             i_b,
    output logic [DIV_W-1:0] o_diff,
    output logic             o_bout
);
    assign {o_bout, o_diff} = {1'b0, i_x} - {1'b0, i_y} - {{DIV_W{1'b0}}, i_b};
endmodule

// File: rtl/restoring_div16.sv
// restoring_div16: sequential 16-bit restoring divider, one trial subtraction per clock; SIGNED_DIV_EN adds signed mode
module restoring_div16
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [DIV_W-1:0] DBZ_QUOT = 16'hFFFF
) (
    input logic            clk,
    input logic            rst_n,
    restoring_div16_if.slave bus
);
    if (WIDTH != DIV_W) begin : g_width_check
        $error("restoring_div16: WIDTH must be 16");
    end

    div_state_t           r_state, w_next;
    logic [DIV_CNT_W-1:0] r_count;
    logic [DIV_W-1:0]     r_r, r_q, r_d, r_quot, r_rem;
    logic                 r_dbz;
    logic                 w_acc, w_msb, w_bout, w_ok;
    logic [DIV_W-1:0]     w_s, w_diff, w_r_nx, w_q_nx;
    logic [DIV_W-1:0]     w_abs_a, w_abs_b, w_res_q, w_res_r;

    assign w_acc = (r_state == IDLE) && bus.start;

    // The 17-bit shifted remainder is {w_msb, w_s}; a set msb means the trial always succeeds
    assign w_msb  = r_r[DIV_W-1];
    assign w_s    = {r_r[DIV_W-2:0], r_q[DIV_W-1]};
    assign w_ok   = w_msb | ~w_bout;
    assign w_r_nx = w_ok ? w_diff : w_s;
    assign w_q_nx = {r_q[DIV_W-2:0], w_ok};

    scazfsc u_sub (
        .i_x    (w_s),
        .i_y    (r_d),
        .i_b    (1'b0),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

`ifdef SIGNED_DIV_EN
    logic w_neg_a, w_neg_b, r_neg_q, r_neg_r;
    assign w_neg_a = bus.signed_op & bus.dividend[DIV_W-1];
    assign w_neg_b = bus.signed_op & bus.divisor[DIV_W-1];
    assign w_abs_a = w_neg_a ? -bus.dividend : bus.dividend;
    assign w_abs_b = w_neg_b ? -bus.divisor : bus.divisor;
    assign w_res_q = r_neg_q ? -w_q_nx : w_q_nx;
    assign w_res_r = r_neg_r ? -w_r_nx : w_r_nx;

    // Result signs are captured with the operands so later input changes cannot affect the fix-up
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_acc) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end
    end
`else
    assign w_abs_a = bus.dividend;
    assign w_abs_b = bus.divisor;
    assign w_res_q = w_q_nx;
    assign w_res_r = w_r_nx;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: divide-by-zero skips RUN, DONE always lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.divisor == '0) ? DONE : RUN;
            RUN:     if (r_count == DIV_LAST) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, one iteration per RUN cycle, results loaded only on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_acc) begin
            r_count <= '0;
            r_r     <= '0;
            r_q     <= w_abs_a;
            r_d     <= w_abs_b;
            r_dbz   <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
                r_quot <= DBZ_QUOT;
                r_rem  <= bus.dividend;
            end
        end else if (r_state == RUN) begin
            r_count <= r_count + DIV_CNT_W'(1);
            r_r     <= w_r_nx;
            r_q     <= w_q_nx;
            if (r_count == DIV_LAST) begin
                r_quot <= w_res_q;
                r_rem  <= w_res_r;
            end
        end
    end

    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_restoring_div16.sv
// tb_restoring_div16: randomized bench for restoring_div16 with an arithmetic reference model and literal spot checks
`timescale 1ns/1ps
module tb_restoring_div16;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    restoring_div16_if bus();

    restoring_div16 #(.WIDTH(16), .DBZ_QUOT(16'hFFFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          edge_n = 0;
    int          done_win = -1;
    int          busy_lo = -1;
    int          busy_hi = -2;
    int          next_ok = 0;
    bit          armed = 1'b0;
    logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    bit          m_dbz = 1'b0, p_dbz = 1'b0, m_s = 1'b0;

    task automatic model_div(input logic [15:0] a, input logic [15:0] b, input bit s,
                             output logic [15:0] q, output logic [15:0] r, output bit z);
        int sa, sb;
        z = (b == 16'd0);
        if (z) begin
            q = 16'hFFFF;
            r = a;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Reference model: acceptance timing as cycle numbers, results from plain arithmetic
    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            armed = 1'b1;
            done_win = -1;
            busy_lo = -1;
            busy_hi = -2;
            next_ok = edge_n + 1;
            m_q = '0;
            m_r = '0;
            m_dbz = 1'b0;
        end else begin
            if (bus.start && edge_n >= next_ok) begin
                m_s = 1'b0;
`ifdef SIGNED_DIV_EN
                m_s = bus.signed_op;
`endif
                model_div(bus.dividend, bus.divisor, m_s, p_q, p_r, p_dbz);
                m_dbz = 1'b0;
                done_win = p_dbz ? edge_n : edge_n + 16;
                busy_lo = p_dbz ? -1 : edge_n;
                busy_hi = p_dbz ? -2 : edge_n + 15;
                next_ok = done_win + 2;
            end
            if (edge_n == done_win) begin
                m_q = p_q;
                m_r = p_r;
                m_dbz = p_dbz;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (armed) begin
            n_cmp++;
            if ({bus.done, bus.busy, bus.div_by_zero, bus.quotient, bus.remainder} !==
                {edge_n == done_win, edge_n >= busy_lo && edge_n <= busy_hi, m_dbz, m_q, m_r}) begin
                n_bad++;
                $display("FAIL cycle%0d: got done=%b busy=%b dbz=%b q=%h r=%h, want done=%b busy=%b dbz=%b q=%h r=%h",
                         edge_n, bus.done, bus.busy, bus.div_by_zero, bus.quotient, bus.remainder,
                         edge_n == done_win, edge_n >= busy_lo && edge_n <= busy_hi, m_dbz, m_q, m_r);
            end
        end
    end

    task automatic set_sign(input bit s);
`ifdef SIGNED_DIV_EN
        bus.signed_op = s;
`else
        if (s) $display("note: signed_op requested in unsigned build");
`endif
    endtask

    task automatic lit(input string nm, input logic [15:0] a, input logic [15:0] b, input bit s,
                       input logic [15:0] eq, input logic [15:0] er, input bit ez, input int lat, input bit poke);
        int  c0;
        bit  seen;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        set_sign(s);
        c0 = edge_n;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            bus.start = poke && (edge_n - c0 == 6);
            bus.dividend = 16'($urandom);
            bus.divisor = 16'($urandom);
            seen = bus.done;
        end
        n_cmp++;
        if (!seen || edge_n - c0 != lat || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
            n_bad++;
            $display("FAIL %s: got seen=%b lat=%0d q=%h r=%h dbz=%b, want lat=%0d q=%h r=%h dbz=%b",
                     nm, seen, edge_n - c0, bus.quotient, bus.remainder, bus.div_by_zero, lat, eq, er, ez);
        end
        if (poke) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return 16'($urandom_range(1, 20));
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        set_sign(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        lit("div_100_7",      16'd100,  16'd7,     1'b0, 16'd14,    16'd2,     1'b0, 17, 1'b0);
        lit("div_65535_1",    16'hFFFF, 16'd1,     1'b0, 16'hFFFF,  16'd0,     1'b0, 17, 1'b0);
        lit("div_msb_path",   16'hFFFF, 16'h8000,  1'b0, 16'd1,     16'h7FFF,  1'b0, 17, 1'b0);
        lit("div_by_zero",    16'd5,    16'd0,     1'b0, 16'hFFFF,  16'd5,     1'b1, 1,  1'b0);
        lit("div_after_dbz",  16'd6,    16'd3,     1'b0, 16'd2,     16'd0,     1'b0, 17, 1'b0);
        lit("div_zero_num",   16'd0,    16'd9,     1'b0, 16'd0,     16'd0,     1'b0, 17, 1'b0);
        lit("div_big_divisor",16'd3,    16'd10,    1'b0, 16'd0,     16'd3,     1'b0, 17, 1'b0);
        lit("div_restart_ign",16'd100,  16'd7,     1'b0, 16'd14,    16'd2,     1'b0, 17, 1'b1);
`ifdef SIGNED_DIV_EN
        lit("sdiv_m7_2",      16'hFFF9, 16'd2,     1'b1, 16'hFFFD,  16'hFFFF,  1'b0, 17, 1'b0);
        lit("sdiv_7_m2",      16'd7,    16'hFFFE,  1'b1, 16'hFFFD,  16'd1,     1'b0, 17, 1'b0);
        lit("sdiv_min_m1",    16'h8000, 16'hFFFF,  1'b1, 16'h8000,  16'd0,     1'b0, 17, 1'b0);
`endif

        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor = 16'd7;
        set_sign(1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_midrun: got busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        repeat (20) @(negedge clk);
        lit("div_9_4",        16'd9,    16'd4,     1'b0, 16'd2,     16'd1,     1'b0, 17, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.dividend = pick();
            bus.divisor = ($urandom_range(0, 9) == 0) ? 16'd0 : pick();
            set_sign(1'($urandom_range(0, 1)));
        end
        rst_n = 1'b1;
        bus.start = 1'b0;
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
